// File: rtl/iob_axistream_arbiter_pkg.sv
// iob_axistream_arbiter_pkg: shared state encoding, skid depth and index-width helper
package iob_axistream_arbiter_pkg;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;
  localparam int SKID_DEPTH = 2;
  function automatic int clog2_n(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/iob_axis_skid.sv
// iob_axis_skid: 2-entry AXI-Stream register slice with registered ready and outputs
module iob_axis_skid
  import iob_axistream_arbiter_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         clk_i,
  input  logic         cke_i,
  input  logic         rst_i,
  input  logic [W-1:0] s_data_i,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  output logic [W-1:0] m_data_o,
  output logic         m_valid_o,
  input  logic         m_ready_i,
  output logic [1:0]   level_o
);
  logic [W-1:0] head, tail;
  logic [1:0] level;
  logic push, pop;
  assign s_ready_o = level != 2'(SKID_DEPTH);
  assign m_valid_o = level != 2'd0;
  assign m_data_o = head;
  assign level_o = level;
  assign push = s_valid_i & s_ready_o;
  assign pop = m_valid_o & m_ready_i;
  // head always holds the oldest beat; tail only fills while head is stalled
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head <= '0;
      tail <= '0;
      level <= 2'd0;
    end else if (cke_i) begin
      if (push && (level == 2'd0 || (level == 2'd1 && pop))) head <= s_data_i;
      else if (pop && level == 2'd2) head <= tail;
      if (push && level == 2'd1 && !pop) tail <= s_data_i;
      level <= level + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: rtl/iob_axistream_arbiter.sv
// iob_axistream_arbiter: packet-locked round-robin arbiter of N_IN AXI-Streams onto one skid-buffered sink
module iob_axistream_arbiter
  import iob_axistream_arbiter_pkg::*;
#(
  parameter int N_IN = 2,
  parameter int TDATA_W = 8,
  parameter int CNT_W = 16
) (
  input  logic                    clk_i,
  input  logic                    cke_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic [N_IN*TDATA_W-1:0] s_axis_tdata_i,
  input  logic [N_IN-1:0]         s_axis_tvalid_i,
  input  logic [N_IN-1:0]         s_axis_tlast_i,
  output logic [N_IN-1:0]         s_axis_tready_o,
  output logic [TDATA_W-1:0]      m_axis_tdata_o,
  output logic                    m_axis_tvalid_o,
  output logic                    m_axis_tlast_o,
  input  logic                    m_axis_tready_i,
  output logic [N_IN-1:0]         grant_o,
  output logic                    busy_o,
  output logic [CNT_W-1:0]        pkt_count_o
);
  localparam int GW = clog2_n(N_IN);
  logic [0:0] state;
  logic [GW-1:0] g_idx, last_grant;
  logic [CNT_W-1:0] pkt_cnt;
  logic [1:0] level;
  logic buf_ready, lock, s_v, s_l, acc;
  logic [TDATA_W-1:0] s_d;
  // first valid port strictly after last, wrapping
  function automatic logic [GW-1:0] rr_pick(input logic [N_IN-1:0] v, input logic [GW-1:0] last);
    int idx;
    rr_pick = last;
    for (int k = N_IN; k >= 1; k--) begin
      idx = (int'(last) + k) % N_IN;
      if (v[idx]) rr_pick = GW'(idx);
    end
  endfunction
  assign lock = state == LOCK;
  assign s_v = s_axis_tvalid_i[g_idx];
  assign s_l = s_axis_tlast_i[g_idx];
  assign s_d = s_axis_tdata_i[int'(g_idx)*TDATA_W +: TDATA_W];
  assign acc = lock & s_v & buf_ready;
  assign grant_o = lock ? N_IN'(1) << g_idx : '0;
  assign s_axis_tready_o = buf_ready ? grant_o : '0;
  assign busy_o = lock | (level != 2'd0);
  assign pkt_count_o = pkt_cnt;
  iob_axis_skid #(.W(TDATA_W + 1)) skid (
    .clk_i(clk_i),
    .cke_i(cke_i),
    .rst_i(rst_i),
    .s_data_i({s_l, s_d}),
    .s_valid_i(lock & s_v),
    .s_ready_o(buf_ready),
    .m_data_o({m_axis_tlast_o, m_axis_tdata_o}),
    .m_valid_o(m_axis_tvalid_o),
    .m_ready_i(m_axis_tready_i),
    .level_o(level)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      g_idx <= '0;
      last_grant <= GW'(N_IN - 1);
      pkt_cnt <= '0;
    end else if (cke_i) begin
      if (!lock && enable_i && |s_axis_tvalid_i) begin
        g_idx <= rr_pick(s_axis_tvalid_i, last_grant);
        state <= LOCK;
      end else if (acc && s_l) begin
        state <= IDLE;
        last_grant <= g_idx;
        pkt_cnt <= pkt_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_iob_axistream_arbiter.sv
// tb_iob_axistream_arbiter: directed packets checked against a queue-based arbiter model
module tb_iob_axistream_arbiter;
  localparam int N = 2, W = 8, C = 4;
  logic clk = 0, cke = 1, rst = 1, en = 1, m_ready = 1;
  logic [N*W-1:0] s_tdata = '0;
  logic [N-1:0] s_tvalid = '0, s_tlast = '0, s_tready, grant;
  logic [W-1:0] m_tdata;
  logic m_tvalid, m_tlast, busy;
  logic [C-1:0] pkt_count;
  int tests = 0, fails = 0;
  logic [8:0] src [N][$];
  int acc_cnt [N] = '{0, 0};
  logic [N-1:0] hs;
  bit run = 0;
  bit mlock = 0, acc_m, picked;
  int mg = 0, mlast = N - 1, mcnt = 0;
  logic [8:0] mq[$], outlog[$], beat;
  int glog[$];
  logic [N-1:0] prev_grant = '0;

  iob_axistream_arbiter #(.N_IN(N), .TDATA_W(W), .CNT_W(C)) dut (
    .clk_i(clk), .cke_i(cke), .rst_i(rst), .enable_i(en),
    .s_axis_tdata_i(s_tdata), .s_axis_tvalid_i(s_tvalid), .s_axis_tlast_i(s_tlast),
    .s_axis_tready_o(s_tready), .m_axis_tdata_o(m_tdata), .m_axis_tvalid_o(m_tvalid),
    .m_axis_tlast_o(m_tlast), .m_axis_tready_i(m_ready), .grant_o(grant), .busy_o(busy),
    .pkt_count_o(pkt_count)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: packet lock, round-robin from last winner, 2-deep output queue
  always @(negedge clk) if (run) begin
    chk("grant", grant, mlock ? 32'(1) << mg : 0);
    chk("s_tready", s_tready, (mlock && mq.size() < 2) ? 32'(1) << mg : 0);
    chk("m_tvalid", m_tvalid, mq.size() > 0);
    chk("busy", busy, mlock || mq.size() > 0);
    chk("pkt_count", pkt_count, mcnt);
    if (mq.size() > 0) begin
      chk("m_tdata", m_tdata, mq[0][7:0]);
      chk("m_tlast", m_tlast, mq[0][8]);
    end
    if (grant != 0 && prev_grant == 0) glog.push_back(int'(grant));
    prev_grant = grant;
    if (!rst && cke && m_tvalid && m_ready) outlog.push_back({m_tlast, m_tdata});
    if (rst) begin
      mlock = 0; mlast = N - 1; mcnt = 0; mq.delete();
    end else if (cke) begin
      acc_m = mlock && s_tvalid[mg] && mq.size() < 2;
      beat = {s_tlast[mg], s_tdata[mg*W +: W]};
      if (mq.size() > 0 && m_ready) void'(mq.pop_front());
      if (acc_m) mq.push_back(beat);
      if (!mlock) begin
        if (en && |s_tvalid) begin
          picked = 0;
          for (int k = 1; k <= N; k++)
            if (!picked && s_tvalid[(mlast + k) % N]) begin
              mg = (mlast + k) % N;
              picked = 1;
            end
          mlock = 1;
        end
      end else if (acc_m && beat[8]) begin
        mlock = 0; mlast = mg; mcnt = (mcnt + 1) % (1 << C);
      end
    end
  end

  // per-port source: presents the head of its queue, pops on handshake
  always begin
    @(negedge clk);
    hs = (rst || !cke) ? '0 : s_tvalid & s_tready;
    @(posedge clk);
    #1;
    for (int p = 0; p < N; p++) begin
      if (hs[p] && src[p].size() > 0) begin
        void'(src[p].pop_front());
        acc_cnt[p]++;
      end
      s_tvalid[p] = src[p].size() > 0;
      if (src[p].size() > 0) begin
        s_tdata[p*W +: W] = src[p][0][7:0];
        s_tlast[p] = src[p][0][8];
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pkt(int p, int first, int n);
    for (int i = 0; i < n; i++) src[p].push_back({i == n - 1, 8'(first + i)});
  endtask

  task automatic drain();
    int k = 0;
    while ((src[0].size() > 0 || src[1].size() > 0 || busy) && k < 300) begin
      cyc(1);
      k++;
    end
    chk("drain_timeout", k < 300, 1);
    cyc(2);
  endtask

  task automatic wait_acc(int p, int n);
    int k = 0;
    while (acc_cnt[p] < n && k < 50) begin
      cyc(1);
      k++;
    end
    chk("acc_timeout", k < 50, 1);
  endtask

  initial begin
    int base, k;
    logic [8:0] exp2 [8] = '{9'h050, 9'h151, 9'h040, 9'h141, 9'h052, 9'h153, 9'h042, 9'h143};
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, k;
    logic [8:0] exp2 [8];
    exp2 = '{9'h050, 9'h151, 9'h040, 9'h141, 9'h052, 9'h153, 9'h042, 9'h143};
    cyc(2);
    rst = 0;
    run = 1;
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_grant", grant, 0);
    chk("rst_tready", s_tready, 0);
    chk("rst_count", pkt_count, 0);

    // 1: single 3-beat packet on port 0
    outlog.delete();
    pkt(0, 'h11, 1); pkt(0, 'h22, 1);
    src[0].delete();
    src[0].push_back(9'h011); src[0].push_back(9'h022); src[0].push_back(9'h133);
    k = 0;
    while (!s_tvalid[0] && k < 5) begin @(negedge clk); k++; end
    @(negedge clk);
    chk("t1_grant_latency", grant, 2'b01);
    drain();
    chk("t1_beats", outlog.size(), 3);
    if (outlog.size() == 3) begin
      chk("t1_b0", outlog[0], 9'h011);
      chk("t1_b1", outlog[1], 9'h022);
      chk("t1_b2", outlog[2], 9'h133);
    end
    chk("t1_count", pkt_count, 1);

    // 2: both ports, two packets each; port 1 wins first as port 0 won last
    outlog.delete(); glog.delete();
    pkt(0, 'h40, 2); pkt(0, 'h42, 2); pkt(1, 'h50, 2); pkt(1, 'h52, 2);
    drain();
    chk("t2_grants", glog.size(), 4);
    if (glog.size() == 4) begin
      chk("t2_g0", glog[0], 2); chk("t2_g1", glog[1], 1);
      chk("t2_g2", glog[2], 2); chk("t2_g3", glog[3], 1);
    end
    chk("t2_beats", outlog.size(), 8);
    if (outlog.size() == 8) for (int i = 0; i < 8; i++) chk("t2_order", outlog[i], exp2[i]);
    chk("t2_count", pkt_count, 5);

    // 3: enable drops mid-packet on port 1
    outlog.delete();
    base = acc_cnt[1];
    pkt(1, 'h9E, 4);
    wait_acc(1, base + 2);
    en = 0;
    pkt(0, 'h60, 2);
    k = 0;
    while ((src[1].size() > 0 || busy) && k < 50) begin cyc(1); k++; end
    chk("t3_timeout", k < 50, 1);
    cyc(5);
    chk("t3_grant", grant, 0);
    chk("t3_busy", busy, 0);
    chk("t3_accepted", acc_cnt[1] - base, 4);
    chk("t3_count", pkt_count, 6);
    if (outlog.size() >= 2) begin
      chk("t3_a0", outlog[outlog.size()-2], 9'h0A0);
      chk("t3_a1", outlog[outlog.size()-1], 9'h1A1);
    end else chk("t3_beats", outlog.size(), 4);
    src[0].delete();
    cyc(2);
    en = 1;
    cyc(1);

    // 4: downstream stall during a 4-beat packet, then a clock-enable gap
    outlog.delete();
    m_ready = 0;
    base = acc_cnt[0];
    pkt(0, 'h70, 4);
    cyc(8);
    chk("t4_buffered", acc_cnt[0] - base, 2);
    chk("t4_tready", s_tready, 0);
    chk("t4_hold_data", m_tdata, 'h70);
    chk("t4_hold_valid", m_tvalid, 1);
    m_ready = 1;
    cke = 0;
    cyc(2);
    chk("t4_cke_hold", m_tdata, 'h70);
    cke = 1;
    drain();
    chk("t4_beats", outlog.size(), 4);
    if (outlog.size() == 4) begin
      chk("t4_b0", outlog[0], 9'h070); chk("t4_b1", outlog[1], 9'h071);
      chk("t4_b2", outlog[2], 9'h072); chk("t4_b3", outlog[3], 9'h173);
    end
    chk("t4_count", pkt_count, 7);

    // 5: reset with two beats of an open packet buffered
    m_ready = 0;
    base = acc_cnt[1];
    pkt(1, 'h80, 4);
    wait_acc(1, base + 2);
    cyc(1);
    rst = 1;
    src[1].delete();
    cyc(1);
    rst = 0;
    chk("t5_m_tvalid", m_tvalid, 0);
    chk("t5_grant", grant, 0);
    chk("t5_count", pkt_count, 0);
    chk("t5_m_tlast", m_tlast, 0);
    m_ready = 1;
    glog.delete();
    pkt(0, 'hC0, 1); pkt(1, 'hD0, 1);
    drain();
    chk("t5_first_grant", glog.size() > 0 ? glog[0] : 0, 1);

    // 6: 17 single-beat packets wrap a 4-bit counter
    rst = 1;
    cyc(1);
    rst = 0;
    for (int i = 0; i < 17; i++) pkt(i % 2, i, 1);
    drain();
    chk("t6_wrap", pkt_count, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
